start_srl_fifo_mc: RTL and testbench
====================================

START_SRL_FIFO_MC -- requirements
Module: start_srl_fifo_mc

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent FIFO channels (1..16).
REQ-002 Parameter DATA_WIDTH, default 1, bits per entry per channel.
REQ-003 Parameter DEPTH, default 2, entries per channel (2..64).
REQ-004 Parameter ADDR_WIDTH, default 1, read-address width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-005 Parameter AF_LEVEL, default DEPTH-1, occupancy at or above which almost-full asserts.
REQ-006 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 if_write  in  CHANNELS  per-channel push request.
REQ-009 if_din  in  CHANNELS*DATA_WIDTH  push data, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-010 if_full_n  out  CHANNELS  1 = channel can accept a push.
REQ-011 if_almost_full_n  out  CHANNELS  0 = occupancy >= AF_LEVEL.
REQ-012 if_read  in  CHANNELS  per-channel pop request.
REQ-013 if_dout  out  CHANNELS*DATA_WIDTH  head entry, packed as if_din.
REQ-014 if_empty_n  out  CHANNELS  1 = if_dout holds a valid head entry.
REQ-015 if_flush  in  CHANNELS  synchronous per-channel discard of all entries.
REQ-016 if_num_data  out  CHANNELS*(ADDR_WIDTH+1)  per-channel occupancy.

Function
REQ-017 Push accepted on a cycle iff if_write[c] && if_full_n[c]; accepted data SHALL enter entry 0, existing entries shifting up by one.
REQ-018 Pop accepted iff if_read[c] && if_empty_n[c]; no data movement on pop, occupancy decrements.
REQ-019 if_dout[c] SHALL be combinationally the entry at address occupancy-1 (first-word-fall-through); undefined value when empty, content not checked.
REQ-020 Latency: data pushed at edge N visible on if_dout with if_empty_n=1 after edge N when channel was empty (one cycle).
REQ-021 Full blocks push even if a pop is accepted the same cycle; empty blocks pop even if a push is accepted the same cycle.
REQ-022 Simultaneous accepted push and pop: occupancy unchanged, shift occurs, read address unchanged.
REQ-023 if_full_n, if_empty_n, if_almost_full_n SHALL be registered, consistent with occupancy after each edge: full_n=0 at DEPTH, empty_n=0 at 0.
REQ-024 if_flush[c] SHALL set occupancy 0, empty_n 0, full_n 1 at the next edge, overriding any push/pop that cycle.
REQ-025 Occupancy SHALL never exceed DEPTH nor wrap below 0.
REQ-026 Channels SHALL be fully independent; activity on one never alters another.

Reset
REQ-027 reset_n low SHALL immediately force all occupancies 0, if_empty_n all 0, if_full_n all 1, if_almost_full_n all 1 (AF_LEVEL>0).
REQ-028 Storage entries SHALL NOT be reset (SRL inference); reset mid-operation discards contents.
REQ-029 Push/pop during reset_n low SHALL be ignored; first accepted push is on the first edge after deassertion.

Structure
REQ-030 Per-channel storage SHALL be one sub-module, start_srl_fifo_mc_shiftreg (we, addr, din, dout, no reset), instantiated CHANNELS times.
REQ-031 Occupancy width function and packed-slice helpers SHALL live in shared package start_srl_fifo_pkg.
REQ-032 Control per channel is a three-state machine EMPTY/PARTIAL/FULL derived from occupancy; no cross-channel logic.

Verification
REQ-033 DEPTH=4, ch0: push 0xA,0xB,0xC,0xD -> full_n=0 after 4th edge; pops return A,B,C,D; empty_n=0 after 4th pop.
REQ-034 Full ch1 with push+pop same cycle -> pop accepted, push dropped, occupancy 3, head advances.
REQ-035 Occupancy 2, push+pop same cycle for 10 cycles -> occupancy stays 2, output order preserved.
REQ-036 AF_LEVEL=3: occupancy 2->3 -> if_almost_full_n falls same edge full_n stays 1.
REQ-037 Flush ch2 at occupancy 3 with simultaneous push -> occupancy 0, empty_n 0, ch0/ch3 untouched.
REQ-038 Assert reset_n low mid-stream between edges -> flags reset without clock; next push after release emerges after 1 cycle.

Source files
------------

// File: rtl/start_srl_fifo_pkg.sv
// start_srl_fifo_pkg: shared state type and sizing helpers for the multichannel SRL FIFO
package start_srl_fifo_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t;

    function automatic int occ_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int slice_lo(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/start_srl_fifo_mc_shiftreg.sv
// start_srl_fifo_mc_shiftreg: unreset shift-register storage with addressed read, one per channel
module start_srl_fifo_mc_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // shift every entry up by one and load the new word into entry 0
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < 2**ADDR_WIDTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/start_srl_fifo_mc.sv
// start_srl_fifo_mc: independent first-word-fall-through SRL FIFOs, one per channel
module start_srl_fifo_mc
    import start_srl_fifo_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic [CHANNELS-1:0]                            if_write,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                 if_din,
    output logic [CHANNELS-1:0]                            if_full_n,
    output logic [CHANNELS-1:0]                            if_almost_full_n,
    input  logic [CHANNELS-1:0]                            if_read,
    output logic [CHANNELS*DATA_WIDTH-1:0]                 if_dout,
    output logic [CHANNELS-1:0]                            if_empty_n,
    input  logic [CHANNELS-1:0]                            if_flush,
    output logic [CHANNELS*occ_width(ADDR_WIDTH)-1:0]      if_num_data
);

    localparam int NW = occ_width(ADDR_WIDTH);
    localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);
    localparam logic [NW-1:0] AF_C    = NW'(AF_LEVEL);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        fifo_state_t     state_q, state_d;
        logic [NW-1:0]   cnt_q, cnt_d;
        logic            af_n_q, af_n_d;
        logic            push, pop;

        assign push = if_write[c] && state_q != ST_FULL;
        assign pop  = if_read[c] && state_q != ST_EMPTY;

        // next occupancy and state; flush discards everything and wins over push/pop
        always_comb begin
            cnt_d   = if_flush[c] ? '0 : cnt_q + NW'(push) - NW'(pop);
            state_d = cnt_d == '0 ? ST_EMPTY : cnt_d == DEPTH_C ? ST_FULL : ST_PARTIAL;
            af_n_d  = cnt_d < AF_C;
        end

        // occupancy, state and almost-full flag registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_EMPTY;
                cnt_q   <= '0;
                af_n_q  <= AF_LEVEL > 0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                af_n_q  <= af_n_d;
            end
        end

        start_srl_fifo_mc_shiftreg #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_sr (
            .clk (clk),
            .we  (push && !if_flush[c]),
            .addr(ADDR_WIDTH'(cnt_q - 1'b1)),
            .din (if_din[slice_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
            .dout(if_dout[slice_lo(c, DATA_WIDTH) +: DATA_WIDTH])
        );

        assign if_full_n[c]                          = state_q != ST_FULL;
        assign if_empty_n[c]                         = state_q != ST_EMPTY;
        assign if_almost_full_n[c]                   = af_n_q;
        assign if_num_data[slice_lo(c, NW) +: NW]    = cnt_q;
    end

endmodule

// File: tb/tb_start_srl_fifo_mc.sv
// tb_start_srl_fifo_mc: table, directed and randomized checks against a queue model
module tb_start_srl_fifo_mc;

    localparam int CH = 4, DW = 4, DEPTH = 4, AW = 2, AF = 3, NW = AW + 1;

    logic              clk = 1'b0, reset_n = 1'b0;
    logic [CH-1:0]     if_write = '0, if_read = '0, if_flush = '0;
    logic [CH*DW-1:0]  if_din = '0;
    logic [CH-1:0]     if_full_n, if_almost_full_n, if_empty_n;
    logic [CH*DW-1:0]  if_dout;
    logic [CH*NW-1:0]  if_num_data;

    int n_chk = 0, n_pass = 0;
    int q [CH][$];

    typedef struct {
        logic w, r;
        int   d, cnt, full_n, empty_n, af_n, dout;
    } vec_t;
    vec_t tbl [9];

    always #5 clk = ~clk;

    start_srl_fifo_mc #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .if_write(if_write), .if_din(if_din),
        .if_full_n(if_full_n), .if_almost_full_n(if_almost_full_n), .if_read(if_read),
        .if_dout(if_dout), .if_empty_n(if_empty_n), .if_flush(if_flush), .if_num_data(if_num_data)
    );

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s ch%0d: got %0d expected %0d", name, c, act, exp);
    endtask

    function automatic int cnt_of(input int c);
        return int'(if_num_data[c*NW +: NW]);
    endfunction

    function automatic int dout_of(input int c);
        return int'(if_dout[c*DW +: DW]);
    endfunction

    task automatic check_model();
        for (int c = 0; c < CH; c++) begin
            chk("num_data", c, cnt_of(c), q[c].size());
            chk("empty_n", c, int'(if_empty_n[c]), int'(q[c].size() != 0));
            chk("full_n", c, int'(if_full_n[c]), int'(q[c].size() != DEPTH));
            chk("almost_full_n", c, int'(if_almost_full_n[c]), int'(q[c].size() < AF));
            if (q[c].size() > 0) chk("dout", c, dout_of(c), q[c][0]);
        end
    endtask

    task automatic step(input logic [CH-1:0] w, input logic [CH-1:0] r,
                        input logic [CH-1:0] f, input logic [CH*DW-1:0] d);
        bit pu [CH];
        bit po [CH];
        if_write = w; if_read = r; if_flush = f; if_din = d;
        for (int c = 0; c < CH; c++) begin
            pu[c] = w[c] && q[c].size() < DEPTH;
            po[c] = r[c] && q[c].size() > 0;
        end
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            if (f[c]) q[c].delete();
            else begin
                if (po[c]) void'(q[c].pop_front());
                if (pu[c]) q[c].push_back(int'(d[c*DW +: DW]));
            end
        end
        #1;
        if_write = '0; if_read = '0; if_flush = '0;
        check_model();
    endtask

    initial begin
        tbl[0] = '{1, 0, 'hA, 1, 1, 1, 1, 'hA};
        tbl[1] = '{1, 0, 'hB, 2, 1, 1, 1, 'hA};
        tbl[2] = '{1, 0, 'hC, 3, 1, 1, 0, 'hA};
        tbl[3] = '{1, 0, 'hD, 4, 0, 1, 0, 'hA};
        tbl[4] = '{0, 1, 0,   3, 1, 1, 0, 'hB};
        tbl[5] = '{0, 1, 0,   2, 1, 1, 1, 'hC};
        tbl[6] = '{0, 1, 0,   1, 1, 1, 1, 'hD};
        tbl[7] = '{0, 1, 0,   0, 1, 0, 1, -1};
        tbl[8] = '{0, 1, 0,   0, 1, 0, 1, -1};

        if_write = '1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            chk("rst_num_data", c, cnt_of(c), 0);
            chk("rst_empty_n", c, int'(if_empty_n[c]), 0);
            chk("rst_full_n", c, int'(if_full_n[c]), 1);
            chk("rst_af_n", c, int'(if_almost_full_n[c]), 1);
        end
        if_write = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            step({3'b0, tbl[i].w}, {3'b0, tbl[i].r}, '0, {12'h0, 4'(tbl[i].d)});
            chk("tbl_cnt", 0, cnt_of(0), tbl[i].cnt);
            chk("tbl_full_n", 0, int'(if_full_n[0]), tbl[i].full_n);
            chk("tbl_empty_n", 0, int'(if_empty_n[0]), tbl[i].empty_n);
            chk("tbl_af_n", 0, int'(if_almost_full_n[0]), tbl[i].af_n);
            if (tbl[i].dout >= 0) chk("tbl_dout", 0, dout_of(0), tbl[i].dout);
        end

        for (int v = 1; v <= 4; v++) step(4'b0010, '0, '0, 16'(v << DW));
        step(4'b0010, 4'b0010, '0, 16'(5 << DW));
        chk("full_pushpop_cnt", 1, cnt_of(1), 3);
        chk("full_pushpop_dout", 1, dout_of(1), 2);
        chk("full_pushpop_full_n", 1, int'(if_full_n[1]), 1);

        step(4'b0001, '0, '0, 16'h0006);
        step(4'b0001, '0, '0, 16'h0007);
        for (int k = 1; k <= 10; k++) begin
            step(4'b0001, 4'b0001, '0, 16'((7 + k) % 16));
            chk("steady_cnt", 0, cnt_of(0), 2);
            chk("steady_dout", 0, dout_of(0), (6 + k) % 16);
        end

        step(4'b1000, '0, '0, 16'h9000);
        for (int v = 1; v <= 3; v++) step(4'b0100, '0, '0, 16'(v << (2 * DW)));
        chk("pre_flush_cnt", 2, cnt_of(2), 3);
        step(4'b0100, '0, 4'b0100, 16'h0E00);
        chk("flush_cnt", 2, cnt_of(2), 0);
        chk("flush_empty_n", 2, int'(if_empty_n[2]), 0);
        chk("flush_full_n", 2, int'(if_full_n[2]), 1);

        for (int i = 0; i < 400; i++)
            step(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15) == 0 ? $urandom : 0), 16'($urandom));

        for (int c = 0; c < CH; c++) step(4'(1 << c), '0, '0, 16'hFFFF);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) begin
            chk("async_rst_num_data", c, cnt_of(c), 0);
            chk("async_rst_empty_n", c, int'(if_empty_n[c]), 0);
            chk("async_rst_full_n", c, int'(if_full_n[c]), 1);
            chk("async_rst_af_n", c, int'(if_almost_full_n[c]), 1);
            q[c].delete();
        end
        if_write = '1;
        @(posedge clk);
        #1;
        chk("rst_push_ignored", 0, cnt_of(0), 0);
        if_write = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b0001, '0, '0, 16'h0009);
        chk("post_rst_empty_n", 0, int'(if_empty_n[0]), 1);
        chk("post_rst_dout", 0, dout_of(0), 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
